// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding a 32-bit logical shifter.
// IDLE accepts one request, EXEC computes the shift, RESP holds the result until taken.
module shift_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic        req0_left_i,
    input  logic [4:0]  req0_shamt_i,
    input  logic [31:0] req0_src_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic        req1_left_i,
    input  logic [4:0]  req1_shamt_i,
    input  logic [31:0] req1_src_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_result_o,
    output logic [15:0] op_count_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        left_q;
    logic        id_q;
    logic        rsp_valid_q;
    logic [4:0]  shamt_q;
    logic [31:0] src_q;
    logic [31:0] result_q;
    logic [15:0] op_count_q;
    logic        grant0;
    logic        grant1;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant0       = req0_valid_i && (!req1_valid_i || last_grant_q);
        grant1       = req1_valid_i && (!req0_valid_i || !last_grant_q);
        req0_ready_o = !rst_i && (state_q == StIdle) && grant0;
        req1_ready_o = !rst_i && (state_q == StIdle) && grant1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            left_q       <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            shamt_q      <= 5'd0;
            src_q        <= 32'd0;
            result_q     <= 32'd0;
            op_count_q   <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0_ready_o || req1_ready_o) begin
                        left_q       <= req1_ready_o ? req1_left_i  : req0_left_i;
                        shamt_q      <= req1_ready_o ? req1_shamt_i : req0_shamt_i;
                        src_q        <= req1_ready_o ? req1_src_i   : req0_src_i;
                        id_q         <= req1_ready_o;
                        last_grant_q <= req1_ready_o;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    result_q    <= left_q ? (src_q << shamt_q) : (src_q >> shamt_q);
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;
    assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration/shift model.
`timescale 1ns/1ps
module tb_shift_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o, req0_left_i;
    logic [4:0]  req0_shamt_i;
    logic [31:0] req0_src_i;
    logic        req1_valid_i, req1_ready_o, req1_left_i;
    logic [4:0]  req1_shamt_i;
    logic [31:0] req1_src_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
    logic [31:0] rsp_result_o;
    logic [15:0] op_count_o;

    int errors = 0;
    int checks = 0;
    int model_last;
    int model_count;

    shift_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_left_i  (req0_left_i),
        .req0_shamt_i (req0_shamt_i),
        .req0_src_i   (req0_src_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_left_i  (req1_left_i),
        .req1_shamt_i (req1_shamt_i),
        .req1_src_i   (req1_src_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_result_o (rsp_result_o),
        .op_count_o   (op_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Shift expressed as multiply/divide by a power of two, truncated to 32 bits.
    function automatic logic [31:0] ref_shift(input logic left, input int amt,
                                              input logic [31:0] src);
        longint unsigned pw = 1;
        longint unsigned wide;
        for (int k = 0; k < amt; k++) pw = pw * 2;
        wide = {32'd0, src};
        if (left) wide = wide * pw;
        else      wide = wide / pw;
        return wide[31:0];
    endfunction

    function automatic int ref_winner(input bit v0, input bit v1, input int last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (v0 && v1)  return (last == 0) ? 1 : 0;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input bit v0, input bit l0, input logic [4:0] s0, input logic [31:0] x0,
                         input bit v1, input bit l1, input logic [4:0] s1, input logic [31:0] x1);
        req0_valid_i = v0; req0_left_i = l0; req0_shamt_i = s0; req0_src_i = x0;
        req1_valid_i = v1; req1_left_i = l1; req1_shamt_i = s1; req1_src_i = x1;
    endtask

    task automatic drive_noise;
        drive(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
              1'($urandom), 1'($urandom), 5'($urandom), $urandom);
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        rsp_ready_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        rst_i = 1'b0;
        model_last = 1;
        model_count = 0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        rsp_ready_i = 1'b1;
        drive(1, 1, 5'd3, 32'h1234, 1, 0, 5'd2, 32'h5678);
        #1;
        checks++;
        if ({req1_ready_o, req0_ready_o} !== 2'b00) begin
            errors++; $display("FAIL reset_ready_async: got %b want 00", {req1_ready_o, req0_ready_o});
        end
        tick;
        #1;
        checks++;
        if ({req1_ready_o, req0_ready_o} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {req1_ready_o, req0_ready_o});
        end
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_id_o !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got valid=%b id=%b want 0 0", rsp_valid_o, rsp_id_o);
        end
        checks++;
        if (rsp_result_o !== 32'd0 || op_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs: got result=%h count=%h want 0 0", rsp_result_o, op_count_o);
        end
        rst_i = 1'b0;
        rsp_ready_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_last = 1;
        model_count = 0;
    endtask

    task automatic test_single;
        do_reset;
        drive(1, 1, 5'd4, 32'h0000_00F1, 0, 0, 0, 0);
        rsp_ready_i = 1'b1;
        #1;
        checks++;
        if ({req1_ready_o, req0_ready_o} !== 2'b01) begin
            errors++; $display("FAIL single_grant: got %b want 01", {req1_ready_o, req0_ready_o});
        end
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL single_exec_valid: got %b want 0", rsp_valid_o);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h0000_0F10 || rsp_id_o !== 1'b0) begin
            errors++;
            $display("FAIL single_resp: got v=%b res=%h id=%b want 1 00000f10 0",
                     rsp_valid_o, rsp_result_o, rsp_id_o);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || op_count_o !== 16'd1) begin
            errors++;
            $display("FAIL single_done: got v=%b count=%0d want 0 1", rsp_valid_o, op_count_o);
        end
        model_last = 0;
        model_count = 1;
    endtask

    task automatic test_contention;
        do_reset;
        drive(1, 0, 5'd31, 32'h8000_0000, 1, 1, 5'd0, 32'hDEAD_BEEF);
        rsp_ready_i = 1'b1;
        #1;
        checks++;
        if ({req1_ready_o, req0_ready_o} !== 2'b01) begin
            errors++; $display("FAIL cont_first_grant: got %b want 01", {req1_ready_o, req0_ready_o});
        end
        tick;
        drive(0, 0, 0, 0, 1, 1, 5'd0, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (req1_ready_o !== 1'b0) begin
            errors++; $display("FAIL cont_exec_ready: got %b want 0", req1_ready_o);
        end
        tick;
        #1;
        checks++;
        if (rsp_result_o !== ref_shift(0, 31, 32'h8000_0000) || rsp_id_o !== 1'b0) begin
            errors++; $display("FAIL cont_resp0: got res=%h id=%b want 00000001 0", rsp_result_o, rsp_id_o);
        end
        tick;
        #1;
        checks++;
        if (req1_ready_o !== 1'b1) begin
            errors++; $display("FAIL cont_second_grant: got %b want 1", req1_ready_o);
        end
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        #1;
        checks++;
        if (rsp_result_o !== 32'hDEAD_BEEF || rsp_id_o !== 1'b1) begin
            errors++; $display("FAIL cont_resp1: got res=%h id=%b want deadbeef 1", rsp_result_o, rsp_id_o);
        end
        tick;
        model_last = 1;
        model_count = 2;
    endtask

    task automatic test_sustained;
        int w;
        logic [31:0] x0, x1, exp_res;
        logic [4:0]  s0, s1;
        bit l0, l1;
        do_reset;
        rsp_ready_i = 1'b1;
        for (int n = 0; n < 6; n++) begin
            x0 = $urandom; x1 = $urandom; s0 = 5'($urandom); s1 = 5'($urandom);
            l0 = 1'($urandom); l1 = 1'($urandom);
            drive(1, l0, s0, x0, 1, l1, s1, x1);
            #1;
            w = ref_winner(1, 1, model_last);
            exp_res = (w == 0) ? ref_shift(l0, s0, x0) : ref_shift(l1, s1, x1);
            checks++;
            if ({req1_ready_o, req0_ready_o} !== ((w == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL sust_grant[%0d]: got %b want winner %0d", n, {req1_ready_o, req0_ready_o}, w);
            end
            tick;
            tick;
            #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_res || rsp_id_o !== 1'(w)) begin
                errors++;
                $display("FAIL sust_resp[%0d]: got v=%b res=%h id=%b want 1 %h %0d",
                         n, rsp_valid_o, rsp_result_o, rsp_id_o, exp_res, w);
            end
            tick;
            model_last = w;
            model_count++;
        end
        checks++;
        if (op_count_o !== 16'd6) begin
            errors++; $display("FAIL sust_count: got %0d want 6", op_count_o);
        end
    endtask

    task automatic test_backpressure;
        int w;
        logic [31:0] x0, exp_res;
        logic [4:0]  s0;
        x0 = $urandom; s0 = 5'($urandom);
        drive(1, 1, s0, x0, 0, 0, 0, 0);
        rsp_ready_i = 1'b0;
        w = ref_winner(1, 0, model_last);
        exp_res = ref_shift(1, s0, x0);
        tick;
        tick;
        for (int k = 0; k < 5; k++) begin
            drive_noise;
            #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_res || rsp_id_o !== 1'(w) ||
                {req1_ready_o, req0_ready_o} !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%b rdy=%b want 1 %h %0d 00", k,
                         rsp_valid_o, rsp_result_o, rsp_id_o, {req1_ready_o, req0_ready_o}, exp_res, w);
            end
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rsp_ready_i = 1'b1;
        tick;
        model_last = w;
        model_count++;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || op_count_o !== 16'(model_count)) begin
            errors++;
            $display("FAIL bp_release: got v=%b count=%0d want 0 %0d", rsp_valid_o, op_count_o, model_count);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] x1;
        logic [4:0]  s1;
        do_reset;
        drive(1, 1, 5'd3, 32'hF0F0_1234, 0, 0, 0, 0);
        rsp_ready_i = 1'b1;
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        model_last = 1;
        model_count = 0;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || op_count_o !== 16'd0) begin
            errors++; $display("FAIL mid_abort: got v=%b count=%0d want 0 0", rsp_valid_o, op_count_o);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL mid_no_resp: got v=%b want 0", rsp_valid_o);
        end
        x1 = $urandom; s1 = 5'($urandom);
        drive(0, 0, 0, 0, 1, 0, s1, x1);
        #1;
        checks++;
        if ({req1_ready_o, req0_ready_o} !== 2'b10) begin
            errors++; $display("FAIL mid_req1_grant: got %b want 10", {req1_ready_o, req0_ready_o});
        end
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        #1;
        checks++;
        if (rsp_result_o !== ref_shift(0, s1, x1) || rsp_id_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_resp: got res=%h id=%b want %h 1", rsp_result_o, rsp_id_o, ref_shift(0, s1, x1));
        end
        tick;
        model_last = 1;
        model_count = 1;
    endtask

    task automatic test_random;
        int w;
        logic [31:0] x0, x1, exp_res;
        logic [4:0]  s0, s1;
        bit v0, v1, l0, l1, rdy, done;
        do_reset;
        for (int n = 0; n < 150; n++) begin
            v0 = 1'($urandom); v1 = 1'($urandom); l0 = 1'($urandom); l1 = 1'($urandom);
            x0 = $urandom; x1 = $urandom; s0 = 5'($urandom); s1 = 5'($urandom);
            if (n % 7 == 0)  s0 = 5'd31;
            if (n % 11 == 0) s1 = 5'd0;
            drive(v0, l0, s0, x0, v1, l1, s1, x1);
            rsp_ready_i = 1'($urandom);
            #1;
            w = ref_winner(v0, v1, model_last);
            checks++;
            if (op_count_o !== 16'(model_count)) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, op_count_o, 16'(model_count));
            end
            checks++;
            if ({req1_ready_o, req0_ready_o} !== ((w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got %b want winner %0d", n, {req1_ready_o, req0_ready_o}, w);
            end
            tick;
            if (w < 0) continue;
            exp_res = (w == 0) ? ref_shift(l0, s0, x0) : ref_shift(l1, s1, x1);
            model_last = w;
            drive_noise;
            rsp_ready_i = 1'($urandom);
            #1;
            checks++;
            if (rsp_valid_o !== 1'b0 || {req1_ready_o, req0_ready_o} !== 2'b00) begin
                errors++;
                $display("FAIL rand_exec[%0d]: got v=%b rdy=%b want 0 00", n, rsp_valid_o,
                         {req1_ready_o, req0_ready_o});
            end
            tick;
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                drive_noise;
                rdy = ($urandom_range(0, 2) != 0) || (k == 19);
                rsp_ready_i = rdy;
                #1;
                checks++;
                if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_res || rsp_id_o !== 1'(w) ||
                    {req1_ready_o, req0_ready_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL rand_resp[%0d]: got v=%b res=%h id=%b rdy=%b want 1 %h %0d 00", n,
                             rsp_valid_o, rsp_result_o, rsp_id_o, {req1_ready_o, req0_ready_o}, exp_res, w);
                end
                tick;
                done = rdy;
            end
            model_count++;
        end
    endtask

    task automatic test_wrap;
        rsp_ready_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        force dut.op_count_q = 16'hFFFE;
        #1;
        release dut.op_count_q;
        model_count = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            drive(1, 0, 5'd1, 32'h2, 0, 0, 0, 0);
            tick;
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick;
            tick;
            model_count = (model_count + 1) % 65536;
            #1;
            checks++;
            if (op_count_o !== 16'(model_count)) begin
                errors++; $display("FAIL wrap_count[%0d]: got %h want %h", n, op_count_o, 16'(model_count));
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_sustained;
        test_backpressure;
        test_reset_mid;
        test_random;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
